// File: rtl/fetch_stage.sv
// fetch_stage: Y86-64 fetch stage with PC, instruction split, status classification and F->D register
module fetch_stage #(
  parameter int          IMEM_BYTES = 4096,
  parameter logic [63:0] RESET_PC   = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [63:0] imem_addr,
  input  logic [79:0] imem_rdata,
  input  logic        imem_err,
  input  logic        f_stall,
  input  logic        d_stall,
  input  logic        d_bubble,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic [63:0] f_pc,
  output logic        f_halted,
  output logic [3:0]  D_icode,
  output logic [3:0]  D_ifun,
  output logic [3:0]  D_rA,
  output logic [3:0]  D_rB,
  output logic [63:0] D_valC,
  output logic [63:0] D_valP,
  output logic [2:0]  D_stat,
  output logic        D_valid
);
  typedef enum logic {RUN, HALTED} state_t;
  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
    logic [2:0]  stat;
    logic        valid;
  } dreg_t;
  localparam dreg_t BUBBLE = '{icode: 4'h1, ifun: 4'h0, ra: 4'hF, rb: 4'hF, valc: 64'h0,
                               valp: 64'h0, stat: 3'd1, valid: 1'b0};
  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d, pred_pc;
  dreg_t       d_q, d_d, fetched;
  logic [3:0]  icode, ifun;
  logic        need_regids, need_valc, adr, ins;
  // Split the instruction window into fields, compute length, status and predicted next PC
  always_comb begin
    icode       = imem_rdata[7:4];
    ifun        = imem_rdata[3:0];
    need_regids = icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
    need_valc   = icode inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
    adr         = imem_err || pc_q >= 64'(IMEM_BYTES);
    ins         = icode > 4'hB || ((icode == 4'h2 || icode == 4'h7) && ifun > 4'h6) ||
                  (icode == 4'h6 && ifun > 4'h3) ||
                  (icode inside {4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB} && ifun != 4'h0);
    fetched.icode = icode;
    fetched.ifun  = ifun;
    fetched.ra    = need_regids ? imem_rdata[15:12] : 4'hF;
    fetched.rb    = need_regids ? imem_rdata[11:8] : 4'hF;
    fetched.valc  = !need_valc ? 64'h0 : need_regids ? imem_rdata[79:16] : imem_rdata[71:8];
    fetched.valp  = pc_q + 64'd1 + 64'(need_regids) + (need_valc ? 64'd8 : 64'd0);
    fetched.stat  = adr ? 3'd3 : ins ? 3'd4 : icode == 4'h0 ? 3'd2 : 3'd1;
    fetched.valid = 1'b1;
    pred_pc = state_q == HALTED ? pc_q :
              (icode == 4'h7 || icode == 4'h8) ? fetched.valc : fetched.valp;
  end
  // Next PC, D register contents and RUN/HALTED transitions in priority order
  always_comb begin
    pc_d    = redirect_valid ? redirect_pc : (f_stall || state_q == HALTED) ? pc_q : pred_pc;
    d_d     = redirect_valid ? BUBBLE : d_stall ? d_q :
              (d_bubble || state_q == HALTED) ? BUBBLE : fetched;
    state_d = redirect_valid ? RUN :
              (state_q == RUN && !d_stall && !d_bubble && fetched.stat != 3'd1) ? HALTED : state_q;
  end
  // State registers with asynchronous reset to RESET_PC, RUN and a bubble in D
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      state_q <= RUN;
      d_q     <= BUBBLE;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      d_q     <= d_d;
    end
  end
  assign imem_addr = pc_q;
  assign f_pc      = pc_q;
  assign f_halted  = state_q == HALTED;
  assign D_icode   = d_q.icode;
  assign D_ifun    = d_q.ifun;
  assign D_rA      = d_q.ra;
  assign D_rB      = d_q.rb;
  assign D_valC    = d_q.valc;
  assign D_valP    = d_q.valp;
  assign D_stat    = d_q.stat;
  assign D_valid   = d_q.valid;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus randomized run against a behavioural fetch model
module tb_fetch_stage;
  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
    logic [2:0]  stat;
    logic        valid;
  } dr_t;
  localparam dr_t BUB = '{icode: 4'h1, ifun: 4'h0, ra: 4'hF, rb: 4'hF, valc: 64'h0,
                          valp: 64'h0, stat: 3'd1, valid: 1'b0};
  logic        clk = 0, rst_n = 1;
  logic [63:0] imem_addr, redirect_pc = 0, f_pc, D_valC, D_valP;
  logic [79:0] imem_rdata;
  logic        imem_err = 0, f_stall = 0, d_stall = 0, d_bubble = 0, redirect_valid = 0;
  logic        f_halted, D_valid;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
  logic [2:0]  D_stat;
  logic [7:0]  mem [4096];
  int          checks = 0, errors = 0;
  logic        chk_en = 0;
  logic [63:0] m_pc;
  logic        m_halt;
  dr_t         m_d;
  int          maxf [12] = '{0, 0, 6, 0, 0, 0, 3, 6, 0, 0, 0, 0};

  fetch_stage #(.IMEM_BYTES(4096), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_err(imem_err),
    .f_stall(f_stall), .d_stall(d_stall), .d_bubble(d_bubble), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .f_pc(f_pc), .f_halted(f_halted), .D_icode(D_icode), .D_ifun(D_ifun),
    .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP), .D_stat(D_stat), .D_valid(D_valid)
  );

  always #5 clk = ~clk;

  always_comb for (int k = 0; k < 10; k++) imem_rdata[8*k +: 8] = mem[12'(imem_addr + 64'(k))];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic dr_t decode(input logic [63:0] pc, input logic err);
    dr_t r;
    logic [7:0] b0, b1;
    logic regs, hasc;
    int off;
    b0 = mem[12'(pc)];
    b1 = mem[12'(pc + 64'd1)];
    r.icode = b0[7:4];
    r.ifun  = b0[3:0];
    regs = r.icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
    hasc = r.icode inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
    r.ra = regs ? b1[7:4] : 4'hF;
    r.rb = regs ? b1[3:0] : 4'hF;
    off = regs ? 2 : 1;
    r.valc = 0;
    if (hasc) for (int k = 0; k < 8; k++) r.valc[8*k +: 8] = mem[12'(pc + 64'(off + k))];
    r.valp = pc + 64'(1 + (regs ? 1 : 0) + (hasc ? 8 : 0));
    if (err || pc >= 64'd4096) r.stat = 3;
    else if (r.icode > 4'hB || int'(r.ifun) > maxf[r.icode]) r.stat = 4;
    else r.stat = r.icode == 0 ? 3'd2 : 3'd1;
    r.valid = 1;
    return r;
  endfunction

  task automatic model_reset();
    m_pc = 0;
    m_halt = 0;
    m_d = BUB;
  endtask

  task automatic model_step();
    dr_t f;
    logic [63:0] npc;
    logic nh;
    if (!rst_n) begin
      model_reset();
      return;
    end
    f = decode(m_pc, imem_err);
    if (redirect_valid) npc = redirect_pc;
    else if (f_stall || m_halt) npc = m_pc;
    else npc = (f.icode == 7 || f.icode == 8) ? f.valc : f.valp;
    nh = redirect_valid ? 1'b0 : (!m_halt && !d_stall && !d_bubble && f.stat != 1) ? 1'b1 : m_halt;
    if (redirect_valid) m_d = BUB;
    else if (!d_stall) m_d = (d_bubble || m_halt) ? BUB : f;
    m_pc = npc;
    m_halt = nh;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic ctl(input logic fs, input logic ds, input logic db, input logic rv, input logic [63:0] rp);
    f_stall = fs;
    d_stall = ds;
    d_bubble = db;
    redirect_valid = rv;
    redirect_pc = rp;
  endtask

  task automatic put(input int a, input logic [79:0] bytes_le, input int n);
    for (int k = 0; k < n; k++) mem[12'(a + k)] = bytes_le[8*k +: 8];
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("imem_addr", imem_addr, m_pc);
    chk("f_pc", f_pc, m_pc);
    chk("f_halted", 64'(f_halted), 64'(m_halt));
    chk("D_icode", 64'(D_icode), 64'(m_d.icode));
    chk("D_ifun", 64'(D_ifun), 64'(m_d.ifun));
    chk("D_rA", 64'(D_rA), 64'(m_d.ra));
    chk("D_rB", 64'(D_rB), 64'(m_d.rb));
    chk("D_valC", D_valC, m_d.valc);
    chk("D_valP", D_valP, m_d.valp);
    chk("D_stat", 64'(D_stat), 64'(m_d.stat));
    chk("D_valid", 64'(D_valid), 64'(m_d.valid));
  end

  task automatic gen_mem();
    int a, ic;
    a = 0;
    while (a < 4096) begin
      if ($urandom_range(0, 15) == 0) begin
        mem[12'(a)] = 8'($urandom);
        a++;
      end else begin
        ic = $urandom_range(0, 29) == 0 ? 0 : $urandom_range(1, 11);
        mem[12'(a)] = {4'(ic), 4'($urandom_range(0, maxf[ic]))};
        a++;
        if (ic inside {2, 3, 4, 5, 6, 10, 11}) begin
          mem[12'(a)] = 8'($urandom);
          a++;
        end
        if (ic inside {3, 4, 5, 7, 8}) begin
          for (int k = 0; k < 8; k++) begin
            mem[12'(a)] = (ic == 7 || ic == 8) ? (k == 0 ? 8'($urandom) : k == 1 ? 8'($urandom_range(0, 15)) : 8'h0)
                                               : 8'($urandom);
            a++;
          end
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    put(0, 80'h00_00_00_00_00_00_00_0A_F2_30, 10);
    for (int i = 10; i < 16; i++) mem[i] = 8'h10;
    put(16, 80'h00_00_00_00_00_00_00_01_00_70, 9);
    put(64, 80'h01_67_01_63, 4);
    mem[80] = 8'hF0;
    for (int i = 96; i < 104; i++) mem[i] = 8'h10;
    #1 rst_n = 0;
    model_reset();
    #1;
    chk("reset_pc", f_pc, 64'h0);
    chk("reset_valid", 64'(D_valid), 64'h0);
    chk("reset_icode", 64'(D_icode), 64'h1);
    chk("reset_halted", 64'(f_halted), 64'h0);
    chk_en = 1;
    @(negedge clk);
    rst_n = 1;
    step();
    chk("irmovq_icode", 64'(D_icode), 64'h3);
    chk("irmovq_rA", 64'(D_rA), 64'hF);
    chk("irmovq_rB", 64'(D_rB), 64'h2);
    chk("irmovq_valC", D_valC, 64'd10);
    chk("irmovq_valP", D_valP, 64'd10);
    chk("irmovq_stat", 64'(D_stat), 64'd1);
    chk("irmovq_pc", f_pc, 64'd10);
    repeat (6) step();
    step();
    chk("jmp_icode", 64'(D_icode), 64'h7);
    chk("jmp_valC", D_valC, 64'h100);
    chk("jmp_valP", D_valP, 64'h19);
    chk("jmp_pc", f_pc, 64'h100);
    ctl(0, 0, 0, 1, 64'h19);
    step();
    chk("redir_pc", f_pc, 64'h19);
    chk("redir_valid", 64'(D_valid), 64'h0);
    ctl(0, 0, 0, 0, 0);
    step();
    chk("halt_stat", 64'(D_stat), 64'd2);
    chk("halt_halted", 64'(f_halted), 64'd1);
    step();
    chk("halted_pc", f_pc, 64'h1A);
    chk("halted_valid", 64'(D_valid), 64'd0);
    chk("halted_icode", 64'(D_icode), 64'd1);
    ctl(0, 0, 0, 1, 64'h40);
    step();
    chk("resume_halted", 64'(f_halted), 64'd0);
    chk("resume_pc", f_pc, 64'h40);
    ctl(0, 0, 0, 0, 0);
    step();
    chk("opq3_stat", 64'(D_stat), 64'd1);
    chk("opq3_pc", f_pc, 64'h42);
    step();
    chk("opq7_stat", 64'(D_stat), 64'd4);
    chk("opq7_halted", 64'(f_halted), 64'd1);
    ctl(0, 0, 0, 1, 64'h50);
    step();
    ctl(0, 0, 0, 0, 0);
    step();
    chk("f0_stat", 64'(D_stat), 64'd4);
    ctl(0, 0, 0, 1, 64'd4096);
    step();
    ctl(0, 0, 0, 0, 0);
    step();
    chk("adr_stat", 64'(D_stat), 64'd3);
    ctl(0, 0, 0, 1, 64'h60);
    step();
    ctl(0, 0, 0, 0, 0);
    step();
    chk("nop_valP", D_valP, 64'h61);
    ctl(1, 1, 0, 0, 0);
    repeat (3) begin
      step();
      chk("stall_pc", f_pc, 64'h61);
      chk("stall_valP", D_valP, 64'h61);
      chk("stall_valid", 64'(D_valid), 64'd1);
    end
    ctl(1, 1, 1, 0, 0);
    step();
    chk("stall_bub_valid", 64'(D_valid), 64'd1);
    ctl(0, 0, 1, 0, 0);
    step();
    chk("bubble_valid", 64'(D_valid), 64'd0);
    chk("bubble_pc", f_pc, 64'h62);
    ctl(0, 0, 0, 1, 64'h10);
    step();
    ctl(0, 0, 0, 0, 0);
    #2 rst_n = 0;
    model_reset();
    #1;
    chk("async_pc", f_pc, 64'h0);
    chk("async_valid", 64'(D_valid), 64'd0);
    chk("async_icode", 64'(D_icode), 64'd1);
    step();
    rst_n = 1;
    step();
    chk("post_reset_icode", 64'(D_icode), 64'h3);
    chk("post_reset_pc", f_pc, 64'd10);
    rst_n = 0;
    model_reset();
    gen_mem();
    step();
    rst_n = 1;
    repeat (3000) begin
      redirect_valid = $urandom_range(0, 99) < 8;
      case ($urandom_range(0, 9))
        0: redirect_pc = 64'(4090 + $urandom_range(0, 12));
        1: redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
        default: redirect_pc = 64'($urandom_range(0, 4095));
      endcase
      d_stall = $urandom_range(0, 99) < 12;
      f_stall = d_stall ? $urandom_range(0, 9) != 0 : $urandom_range(0, 99) < 8;
      d_bubble = $urandom_range(0, 99) < 10;
      imem_err = $urandom_range(0, 99) < 3;
      step();
    end
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
